// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake bundle for the UART transmitter FIFO.
// The producer drives valid/data; the FIFO answers with ready.
interface uart_tx_fifo_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO.
// Frame format is latched per frame, and optional CTS flow control gates frame starts.
module uart_tx_fifo #(
  parameter int   FIFO_DEPTH = 16,
  parameter int   DIV_W      = 16,
  localparam int  CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        data_bits,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  input  logic              tx_en,
  input  logic              cts_en,
  input  logic              cts_n,
  uart_tx_fifo_if.slave     wr,
  output logic              tx,
  output logic              busy,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              tx_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic [7:0] frame_mask(input logic [1:0] bits);
    logic [7:0] m;
    case (bits)
      2'b00:   m = 8'h1F;
      2'b01:   m = 8'h3F;
      2'b10:   m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic parity_calc(input logic [7:0] d, input logic [1:0] bits,
                                       input logic odd);
    return (^(d & frame_mask(bits))) ^ odd;
  endfunction

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  state_t           state_r;
  logic [DIV_W-1:0] timer_r;
  logic [DIV_W-1:0] div_r;
  logic [1:0]       bits_r;
  logic             par_en_r;
  logic             par_r;
  logic             stop2_r;
  logic [2:0]       bit_idx_r;
  logic             stop_idx_r;
  logic [7:0]       shift_r;
  logic             tx_r;
  logic             busy_r;
  logic             tx_done_r;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             start_ok_s;
  logic             bit_end_s;
  logic             frame_end_s;
  logic [2:0]       last_idx_s;
  logic [7:0]       head_s;

  assign full_s      = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty_s     = (count_r == {CNT_W{1'b0}});
  assign start_ok_s  = !empty_s && tx_en && (!cts_en || !cts_n);
  assign bit_end_s   = (timer_r == div_r);
  assign frame_end_s = (state_r == STOP) && bit_end_s && (!stop2_r || stop_idx_r);
  // A pop only happens where a frame may start: from IDLE or straight out of STOP.
  assign pop_s       = start_ok_s && ((state_r == IDLE) || frame_end_s);
  assign push_s      = wr.wr_valid && !full_s;
  assign last_idx_s  = {1'b0, bits_r} + 3'd4;
  assign head_s      = mem_r[rd_ptr_r];

  assign wr.wr_ready = !full_s;
  assign fifo_full   = full_s;
  assign fifo_empty  = empty_s;
  assign fifo_count  = count_r;
  assign tx          = tx_r;
  assign busy        = busy_r;
  assign tx_done     = tx_done_r;

  // FIFO storage write port.
  always_ff @(posedge pclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr.wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Transmit FSM with bit timer; a frame load at the bottom overrides the case.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_r    <= IDLE;
      timer_r    <= {DIV_W{1'b0}};
      div_r      <= {DIV_W{1'b0}};
      bits_r     <= 2'b00;
      par_en_r   <= 1'b0;
      par_r      <= 1'b0;
      stop2_r    <= 1'b0;
      bit_idx_r  <= 3'd0;
      stop_idx_r <= 1'b0;
      shift_r    <= 8'h00;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;
      if (state_r != IDLE) begin
        timer_r <= bit_end_s ? {DIV_W{1'b0}} : timer_r + DIV_W'(1);
      end
      case (state_r)
        IDLE: begin
          timer_r <= {DIV_W{1'b0}};
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
        START: begin
          if (bit_end_s) begin
            state_r <= DATA;
            tx_r    <= shift_r[0];
          end
        end
        DATA: begin
          if (bit_end_s) begin
            if (bit_idx_r == last_idx_s) begin
              state_r <= par_en_r ? PARITY : STOP;
              tx_r    <= par_en_r ? par_r : 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            state_r <= STOP;
            tx_r    <= 1'b1;
          end
        end
        STOP: begin
          if (frame_end_s) begin
            tx_done_r <= 1'b1;
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            tx_r      <= 1'b1;
          end else if (bit_end_s) begin
            stop_idx_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
      if (pop_s) begin
        state_r    <= START;
        busy_r     <= 1'b1;
        tx_r       <= 1'b0;
        timer_r    <= {DIV_W{1'b0}};
        bit_idx_r  <= 3'd0;
        stop_idx_r <= 1'b0;
        shift_r    <= head_s;
        div_r      <= baud_div;
        bits_r     <= data_bits;
        par_en_r   <= parity_en;
        par_r      <= parity_calc(head_s, data_bits, parity_odd);
        stop2_r    <= stop2;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frames are predicted from the frame
// format rules (start, N data bits LSB first, parity, stop bits) and a byte queue.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int DIV_W = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [15:0] div;
    logic [1:0]  dbits;
    logic        pen;
    logic        podd;
    logic        s2;
  } cfg_t;

  logic             pclk = 1'b0;
  logic             preset_n;
  logic [15:0]      baud_div;
  logic [1:0]       data_bits;
  logic             parity_en, parity_odd, stop2, tx_en, cts_en, cts_n;
  logic             tx, busy, fifo_empty, fifo_full, tx_done;
  logic [CNT_W-1:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic cap_tx   [1024];
  logic cap_busy [1024];
  logic cap_done [1024];

  uart_tx_fifo_if wr_if ();

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .baud_div   (baud_div),
    .data_bits  (data_bits),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .tx_en      (tx_en),
    .cts_en     (cts_en),
    .cts_n      (cts_n),
    .wr         (wr_if),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .tx_done    (tx_done)
  );

  always #5 pclk = ~pclk;

  function automatic cfg_t mk_cfg(input int div, input int dbits, input bit pen,
                                  input bit podd, input bit s2);
    cfg_t c;
    c.div   = 16'(div);
    c.dbits = 2'(dbits);
    c.pen   = pen;
    c.podd  = podd;
    c.s2    = s2;
    return c;
  endfunction

  function automatic cfg_t rand_cfg(input int maxdiv);
    return mk_cfg($urandom_range(maxdiv, 0), $urandom_range(3, 0), 1'($urandom_range(1, 0)),
                  1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
  endfunction

  // Number of bit periods in one frame: start + N data + parity + stop(s).
  function automatic int nbits(input cfg_t c);
    return 1 + (int'(c.dbits) + 5) + int'(c.pen) + (c.s2 ? 2 : 1);
  endfunction

  function automatic int flen(input cfg_t c);
    return nbits(c) * (int'(c.div) + 1);
  endfunction

  // Line level during bit period k of a frame carrying byte d.
  function automatic logic level(input logic [7:0] d, input cfg_t c, input int k);
    int n;
    int ones;
    n    = int'(c.dbits) + 5;
    ones = 0;
    if (k == 0) return 1'b0;
    if (k <= n) return d[k-1];
    if (c.pen && k == n + 1) begin
      for (int i = 0; i < n; i++) ones += int'(d[i]);
      return 1'((ones % 2) == 1) ^ c.podd;
    end
    return 1'b1;
  endfunction

  task automatic apply_cfg(input cfg_t c);
    baud_div   = c.div;
    data_bits  = c.dbits;
    parity_en  = c.pen;
    parity_odd = c.podd;
    stop2      = c.s2;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
      cap_tx[i]   = tx;
      cap_busy[i] = busy;
      cap_done[i] = tx_done;
    end
  endtask

  task automatic do_reset();
    @(negedge pclk);
    preset_n        = 1'b0;
    wr_if.wr_valid  = 1'b0;
    wr_if.wr_data   = 8'h00;
    tx_en           = 1'b1;
    cts_en          = 1'b0;
    cts_n           = 1'b1;
    apply_cfg(mk_cfg(1, 3, 1'b0, 1'b0, 1'b0));
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    preset_n = 1'b1;
    @(posedge pclk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_if.wr_data  = b;
    wr_if.wr_valid = 1'b1;
    @(posedge pclk);
    #1;
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    preset_n       = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 8'h00;
    tx_en = 1'b0; cts_en = 1'b0; cts_n = 1'b1;
    apply_cfg(mk_cfg(1, 3, 1'b0, 1'b0, 1'b0));
    #22;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", tx_done); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
    n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", fifo_full); end
    n_checks++; if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", wr_if.wr_ready); end
    do_reset();
  endtask

  task automatic test_8n1();
    cfg_t c;
    int   dones;
    do_reset();
    c = mk_cfg(3, 3, 1'b0, 1'b0, 1'b0);
    apply_cfg(c);
    push(8'h0A);
    capture(42);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      n_checks++;
      if (cap_tx[i] !== level(8'h0A, c, i / 4)) begin
        n_fail++; $display("FAIL 8n1_tx[%0d]: got %b want %b", i, cap_tx[i], level(8'h0A, c, i / 4));
      end
      n_checks++;
      if (cap_busy[i] !== 1'b1) begin n_fail++; $display("FAIL 8n1_busy[%0d]: got %b want 1", i, cap_busy[i]); end
    end
    for (int i = 0; i < 42; i++) dones += int'(cap_done[i]);
    n_checks++; if (cap_done[40] !== 1'b1) begin n_fail++; $display("FAIL 8n1_done_pos: got %b want 1", cap_done[40]); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL 8n1_done_count: got %0d want 1", dones); end
    n_checks++; if (cap_busy[40] !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy_end: got %b want 0", cap_busy[40]); end
    n_checks++; if (cap_tx[40] !== 1'b1) begin n_fail++; $display("FAIL 8n1_idle_tx: got %b want 1", cap_tx[40]); end
  endtask

  task automatic test_7e1();
    logic [10:0] seq;
    do_reset();
    apply_cfg(mk_cfg(0, 2, 1'b1, 1'b0, 1'b1));
    seq = 11'b110_1000_0010;
    push(8'h41);
    capture(13);
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (cap_tx[i] !== seq[i]) begin n_fail++; $display("FAIL 7e1_tx[%0d]: got %b want %b", i, cap_tx[i], seq[i]); end
    end
    n_checks++; if (cap_done[11] !== 1'b1) begin n_fail++; $display("FAIL 7e1_done: got %b want 1", cap_done[11]); end
    n_checks++; if (cap_busy[11] !== 1'b0) begin n_fail++; $display("FAIL 7e1_busy_end: got %b want 0", cap_busy[11]); end
  endtask

  task automatic test_fifo_full();
    cfg_t       c;
    logic [7:0] q[$];
    logic [7:0] b;
    int         fl;
    int         dones;
    do_reset();
    tx_en = 1'b0;
    c = rand_cfg(2);
    apply_cfg(c);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      wr_if.wr_data  = b;
      wr_if.wr_valid = 1'b1;
      @(posedge pclk);
      if (q.size() < DEPTH) q.push_back(b);
      #1;
    end
    wr_if.wr_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'(q.size())) begin n_fail++; $display("FAIL full_count: got %0d want %0d", fifo_count, q.size()); end
    n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", fifo_full); end
    n_checks++; if (wr_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", wr_if.wr_ready); end
    n_checks++; if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b want 0", fifo_empty); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL full_held_tx: got %b want 1", tx); end
    tx_en = 1'b1;
    fl = flen(c);
    capture(4 * fl + 2);
    dones = 0;
    for (int i = 0; i < 4 * fl; i++) begin
      n_checks++;
      if (cap_tx[i] !== level(q[i / fl], c, (i % fl) / (int'(c.div) + 1))) begin
        n_fail++; $display("FAIL b2b_tx[%0d]: got %b want %b", i, cap_tx[i],
                           level(q[i / fl], c, (i % fl) / (int'(c.div) + 1)));
      end
      n_checks++;
      if (cap_busy[i] !== 1'b1) begin n_fail++; $display("FAIL b2b_busy[%0d]: got %b want 1", i, cap_busy[i]); end
    end
    for (int i = 0; i < 4 * fl + 2; i++) dones += int'(cap_done[i]);
    n_checks++; if (dones != 4) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 4", dones); end
    n_checks++; if (cap_busy[4 * fl] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", cap_busy[4 * fl]); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL b2b_count_end: got %0d want 0", fifo_count); end
  endtask

  task automatic test_baud_change();
    cfg_t       c1, c2;
    logic [7:0] a, b;
    int         f1, f2;
    do_reset();
    tx_en = 1'b0;
    c1 = mk_cfg(3, 3, 1'b0, 1'b0, 1'b0);
    c2 = mk_cfg(7, 3, 1'b0, 1'b0, 1'b0);
    apply_cfg(c1);
    a = 8'($urandom);
    b = 8'($urandom);
    push(a);
    push(b);
    tx_en = 1'b1;
    f1 = flen(c1);
    f2 = flen(c2);
    fork
      capture(f1 + f2 + 2);
      begin
        repeat (6) @(posedge pclk);
        #2;
        baud_div = 16'd7;
      end
    join
    for (int i = 0; i < f1 + f2; i++) begin
      n_checks++;
      if (i < f1) begin
        if (cap_tx[i] !== level(a, c1, i / 4)) begin
          n_fail++; $display("FAIL baud_f1_tx[%0d]: got %b want %b", i, cap_tx[i], level(a, c1, i / 4));
        end
      end else begin
        if (cap_tx[i] !== level(b, c2, (i - f1) / 8)) begin
          n_fail++; $display("FAIL baud_f2_tx[%0d]: got %b want %b", i, cap_tx[i], level(b, c2, (i - f1) / 8));
        end
      end
    end
    n_checks++; if (cap_done[f1] !== 1'b1) begin n_fail++; $display("FAIL baud_done1: got %b want 1", cap_done[f1]); end
    n_checks++; if (cap_done[f1 + f2] !== 1'b1) begin n_fail++; $display("FAIL baud_done2: got %b want 1", cap_done[f1 + f2]); end
  endtask

  task automatic test_cts();
    cfg_t       c;
    logic [7:0] a;
    int         fl;
    do_reset();
    cts_en = 1'b1;
    cts_n  = 1'b1;
    c = mk_cfg(1, 3, 1'b0, 1'b0, 1'b0);
    apply_cfg(c);
    a = 8'($urandom);
    push(a);
    push(8'($urandom));
    capture(10);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0) begin
        n_fail++; $display("FAIL cts_hold[%0d]: got tx=%b busy=%b want tx=1 busy=0", i, cap_tx[i], cap_busy[i]);
      end
    end
    n_checks++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL cts_count_hold: got %0d want 2", fifo_count); end
    cts_n = 1'b0;
    fl = flen(c);
    fork
      capture(fl + 10);
      begin
        @(posedge pclk);
        #2;
        cts_n = 1'b1;
      end
    join
    for (int i = 0; i < fl + 10; i++) begin
      n_checks++;
      if (i < fl) begin
        if (cap_tx[i] !== level(a, c, i / 2)) begin
          n_fail++; $display("FAIL cts_frame_tx[%0d]: got %b want %b", i, cap_tx[i], level(a, c, i / 2));
        end
      end else begin
        if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0) begin
          n_fail++; $display("FAIL cts_wait[%0d]: got tx=%b busy=%b want tx=1 busy=0", i, cap_tx[i], cap_busy[i]);
        end
      end
    end
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL cts_count_end: got %0d want 1", fifo_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply_cfg(mk_cfg(3, 3, 1'b0, 1'b0, 1'b0));
    push(8'h00);
    push(8'h00);
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL pushpop_count: got %0d want 1", fifo_count); end
    repeat (8) @(posedge pclk);
    #3;
    n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_data_tx: got %b want 0", tx); end
    preset_n = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL areset_tx: got %b want 1", tx); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL areset_count: got %0d want 0", fifo_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", busy); end
    n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL areset_empty: got %b want 1", fifo_empty); end
    #3;
    preset_n = 1'b1;
    capture(50);
    for (int i = 0; i < 50; i++) begin
      n_checks++;
      if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0) begin
        n_fail++; $display("FAIL residual[%0d]: got tx=%b busy=%b want tx=1 busy=0", i, cap_tx[i], cap_busy[i]);
      end
    end
  endtask

  task automatic test_random();
    cfg_t       c;
    logic [7:0] d;
    int         fl, k;
    do_reset();
    for (int it = 0; it < 10; it++) begin
      c = rand_cfg(3);
      apply_cfg(c);
      tx_en  = 1'b1;
      cts_en = 1'b0;
      d = 8'($urandom);
      push(d);
      fl = flen(c);
      k  = $urandom_range(fl, 1);
      fork
        capture(fl + 2);
        begin
          repeat (k) @(posedge pclk);
          #2;
          apply_cfg(rand_cfg(7));
          tx_en = 1'($urandom_range(1, 0));
        end
      join
      for (int i = 0; i < fl; i++) begin
        n_checks++;
        if (cap_tx[i] !== level(d, c, i / (int'(c.div) + 1))) begin
          n_fail++; $display("FAIL rand%0d_tx[%0d]: got %b want %b", it, i, cap_tx[i],
                             level(d, c, i / (int'(c.div) + 1)));
        end
      end
      n_checks++;
      if (cap_done[fl] !== 1'b1 || cap_busy[fl] !== 1'b0 || cap_tx[fl] !== 1'b1) begin
        n_fail++; $display("FAIL rand%0d_end: got done=%b busy=%b tx=%b want 1 0 1", it, cap_done[fl],
                           cap_busy[fl], cap_tx[fl]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e1();
    test_fifo_full();
    test_baud_change();
    test_cts();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, TX FIFO entries; power of two, minimum 2.
REQ-002 SHALL have parameter DIV_W, default 16, baud divisor width.
REQ-003 SHALL have localparam CNT_W = $clog2(FIFO_DEPTH)+1.
REQ-004 pclk  in  1  single clock; all state updates on its rising edge.
REQ-005 preset_n  in  1  asynchronous, active-low reset.
REQ-006 baud_div  in  DIV_W  each bit lasts baud_div+1 pclk cycles.
REQ-007 data_bits  in  2  frame data length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-008 parity_en  in  1  append parity bit when 1.
REQ-009 parity_odd  in  1  1=odd parity, 0=even parity.
REQ-010 stop2  in  1  1=two stop bits, 0=one stop bit.
REQ-011 tx_en  in  1  permits new frames to start.
REQ-012 cts_en  in  1  enables CTS flow control.
REQ-013 cts_n  in  1  clear-to-send, active low.
REQ-014 wr_valid  in  1  push request.
REQ-015 wr_data  in  8  byte to push.
REQ-016 wr_ready  out  1  equals !fifo_full.
REQ-017 tx  out  1  serial line; idle high.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 fifo_count  out  CNT_W  occupancy, 0..FIFO_DEPTH.
REQ-020 fifo_empty / fifo_full  out  1 each  occupancy flags.
REQ-021 tx_done  out  1  one-cycle pulse at the end of the last stop bit.

Function
REQ-022 Push SHALL occur on an edge with wr_valid && wr_ready; writes while full SHALL be dropped with no state change.
REQ-023 Push and pop on the same edge SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-025 IDLE->START on an edge where !fifo_empty && tx_en && (!cts_en || !cts_n); that edge SHALL pop the head entry, and tx SHALL be 0 from that edge.
REQ-026 On the same edge, baud_div, data_bits, parity_en, parity_odd and stop2 SHALL be latched; changes mid-frame SHALL have no effect until the next frame.
REQ-027 Bit timer SHALL count 0..latched baud_div, and the state/bit advances when the timer wraps; every bit period SHALL be exactly baud_div+1 cycles.
REQ-028 DATA SHALL send N = 5..8 bits LSB first; bits above N-1 SHALL be ignored.
REQ-029 PARITY (only if parity_en) SHALL send the XOR of the N data bits, inverted when parity_odd.
REQ-030 STOP SHALL drive tx=1 for 1 or 2 bit periods; at its end tx_done SHALL pulse.
REQ-031 At the end of STOP, when the REQ-025 start condition holds, the FSM SHALL go directly to START, giving back-to-back frames with no idle gap; otherwise it SHALL go to IDLE.
REQ-032 cts_n and tx_en SHALL be sampled only at frame start; deassertion mid-frame SHALL complete the current frame.
REQ-033 Frame length SHALL be (1+N+P+S)*(baud_div+1) cycles, where P = parity_en and S = 1 or 2 stop bits.

Reset
REQ-034 preset_n low SHALL immediately force: state IDLE, tx=1, busy=0, tx_done=0, pointers and fifo_count=0, fifo_empty=1, fifo_full=0, wr_ready=1.
REQ-035 Reset mid-frame SHALL abort the frame and discard FIFO contents; tx SHALL return high asynchronously.

Verification
REQ-036 8N1, baud_div=3, push 0x0A -> tx low 4 cycles, then bits 0,1,0,1,0,0,0,0 at 4 cycles each, stop high 4 cycles; busy high for 40 cycles; single tx_done pulse.
REQ-037 7E1 with stop2=1, baud_div=0, push 0x41 -> tx sequence 0,1,0,0,0,0,0,1,0,1,1; total 11 cycles; parity bit 0.
REQ-038 FIFO_DEPTH=4, tx_en=0, push 6 bytes -> fifo_count=4, fifo_full=1, wr_ready=0; last 2 bytes dropped; with tx_en=1, 4 frames sent back-to-back with no gap.
REQ-039 cts_en=1, cts_n=1, FIFO non-empty -> tx stays 1; cts_n=0 -> frame starts on that edge; cts_n=1 mid-frame -> frame completes and the next one waits.
REQ-040 Assert preset_n=0 during DATA -> tx=1 and fifo_count=0 immediately; after release, no residual frame is sent.
REQ-041 baud_div changed from 3 to 7 mid-frame -> current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
